// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, adder operand mux, branch decision and run/halt FSM; return stack under PC_SEQ_RAS_EN
module pc_sequencer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pc_write,
    input  logic [2:0]       br_type,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             flag_n,
    input  logic             flag_z,
    input  logic             flags_write,
    input  logic [WIDTH-1:0] add_sum,
    output logic [WIDTH-1:0] add_in1,
    output logic [WIDTH-1:0] add_in2,
    output logic [WIDTH-1:0] pc,
    output logic             taken,
    output logic             running,
`ifdef PC_SEQ_RAS_EN
    output logic             ras_err,
`endif
    output logic             halted
);

    localparam logic [2:0] BT_SEQ  = 3'b000;
    localparam logic [2:0] BT_BR   = 3'b001;
    localparam logic [2:0] BT_BZ   = 3'b010;
    localparam logic [2:0] BT_BNZ  = 3'b011;
    localparam logic [2:0] BT_BPZ  = 3'b100;
    localparam logic [2:0] BT_CALL = 3'b101;
    localparam logic [2:0] BT_RET  = 3'b110;
    localparam logic [2:0] BT_HALT = 3'b111;

    if (RAS_DEPTH < 1) begin : g_bad_depth
        $error("RAS_DEPTH must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t state, state_nxt;
    logic   n_q, z_q;
    logic   pc_commit;

    assign running   = (state == S_RUN);
    assign halted    = (state == S_HALT);
    // HALT never moves the pc; every other type loads the adder sum
    assign pc_commit = running && pc_write && (br_type != BT_HALT);

    // Run/halt state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: start only leaves IDLE, HALT is left only through reset
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (pc_write && br_type == BT_HALT) state_nxt = S_HALT;
            default: state_nxt = state;
        endcase
    end

    // Flags are registered; a branch in the same cycle still sees the old values
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else if (flags_write) begin
            n_q <= flag_n;
            z_q <= flag_z;
        end
    end

    // Branch decision, suppressed whenever the sequencer is not running
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BT_BR, BT_CALL: taken = 1'b1;
            BT_BZ:          taken = z_q;
            BT_BNZ:         taken = !z_q;
            BT_BPZ:         taken = !n_q;
            default:        taken = 1'b0;
        endcase
        if (!running) taken = 1'b0;
    end

    // PC captures the zero-latency adder result on a committed write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         pc <= RESET_PC;
        else if (pc_commit) pc <= add_sum;
    end

`ifdef PC_SEQ_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [PW:0]      ras_cnt;
    logic [PW-1:0]    ptr_inc, ptr_dec;
    logic             ras_full, ras_empty, ras_push, ras_pop;

    // ras_ptr is the next free slot; the top of stack sits just below it
    assign ptr_inc   = (ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;
    assign ptr_dec   = (ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
    assign ras_full  = (ras_cnt == (PW + 1)'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);
    assign ras_push  = pc_commit && (br_type == BT_CALL);
    assign ras_pop   = pc_commit && (br_type == BT_RET);

    // Stack storage; a push when full overwrites the oldest slot
    always_ff @(posedge clock) begin
        if (ras_push) ras_mem[ras_ptr] <= pc;
    end

    // Stack pointer, occupancy and sticky overflow/underflow error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_err <= 1'b0;
        end else if (ras_push) begin
            ras_ptr <= ptr_inc;
            if (ras_full) ras_err <= 1'b1;
            else          ras_cnt <= ras_cnt + 1'b1;
        end else if (ras_pop) begin
            if (ras_empty) begin
                ras_err <= 1'b1;
            end else begin
                ras_ptr <= ptr_dec;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end
`endif

    // Adder operands: branch target, return address + 1, or pc + 1
    always_comb begin
        add_in1 = pc;
        add_in2 = WIDTH'(1);
        if (taken) begin
            add_in2 = br_offset;
        end
`ifdef PC_SEQ_RAS_EN
        else if (br_type == BT_RET && !ras_empty) begin
            add_in1 = ras_mem[ptr_dec];
        end
`endif
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized scoreboard bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

    localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, BZ = 3'd2, BNZ = 3'd3;
    localparam logic [2:0] BPZ = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, pc_write = 1'b0;
    logic [2:0] br_type = 3'd0;
    logic [7:0] br_offset = 8'd0;
    logic       flag_n = 1'b0, flag_z = 1'b0, flags_write = 1'b0;
    logic [7:0] add_sum, add_in1, add_in2, pc;
    logic       taken, running, halted;
`ifdef PC_SEQ_RAS_EN
    logic       ras_err;
`endif

    pc_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .pc_write(pc_write),
        .br_type(br_type), .br_offset(br_offset), .flag_n(flag_n), .flag_z(flag_z),
        .flags_write(flags_write), .add_sum(add_sum), .add_in1(add_in1), .add_in2(add_in2),
        .pc(pc), .taken(taken), .running(running),
`ifdef PC_SEQ_RAS_EN
        .ras_err(ras_err),
`endif
        .halted(halted)
    );

    always #5 clock = ~clock;

    // External zero-latency adder
    assign add_sum = add_in1 + add_in2;

    typedef struct {
        int         id;
        logic       taken;
        logic [7:0] in1, in2, pc;
        logic       running, halted, err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_id = 0;

    // Reference model state
    bit         m_run, m_halt, m_n, m_z, m_err;
    logic [7:0] m_pc;
    logic [7:0] m_ras[$];

    function automatic bit model_taken();
        if (!m_run) return 1'b0;
        case (br_type)
            BR, CALL: return 1'b1;
            BZ:       return m_z;
            BNZ:      return !m_z;
            BPZ:      return !m_n;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic exp_t build_exp();
        exp_t e;
        e.id = step_id;
        e.taken = model_taken();
        e.in1 = m_pc;
        e.in2 = e.taken ? br_offset : 8'd1;
`ifdef PC_SEQ_RAS_EN
        if (!e.taken && br_type == RET && m_ras.size() > 0) e.in1 = m_ras[m_ras.size() - 1];
`endif
        e.pc = m_pc;
        e.running = m_run;
        e.halted = m_halt;
        e.err = m_err;
        return e;
    endfunction

    // Advance the model across one rising edge
    task automatic model_edge();
        logic [7:0] nxt;
        if (m_run && pc_write) begin
            if (br_type == HALT) begin
                m_run = 0;
                m_halt = 1;
            end else begin
                nxt = model_taken() ? m_pc + br_offset : m_pc + 8'd1;
`ifdef PC_SEQ_RAS_EN
                if (br_type == CALL) begin
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        m_err = 1;
                    end
                    m_ras.push_back(m_pc);
                end else if (br_type == RET) begin
                    if (m_ras.size() > 0) nxt = m_ras.pop_back() + 8'd1;
                    else m_err = 1;
                end
`endif
                m_pc = nxt;
            end
        end else if (!m_run && !m_halt && start) begin
            m_run = 1;
        end
        if (flags_write) begin
            m_n = flag_n;
            m_z = flag_z;
        end
    endtask

    task automatic step(input bit st, input bit pw, input logic [2:0] bt, input logic [7:0] off,
                        input bit fn, input bit fz, input bit fw);
        @(negedge clock);
        start = st; pc_write = pw; br_type = bt; br_offset = off;
        flag_n = fn; flag_z = fz; flags_write = fw;
        #1;
        step_id++;
        sb.push_back(build_exp());
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        start = 0; pc_write = 0; br_type = SEQ; br_offset = 0;
        flag_n = 0; flag_z = 0; flags_write = 0;
        m_run = 0; m_halt = 0; m_n = 0; m_z = 0; m_err = 0; m_pc = 8'h00;
        m_ras.delete();
        step_id++;
        sb.push_back(build_exp());
        @(negedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic go_to(input logic [7:0] target);
        step(0, 1, BR, target - m_pc, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", nm, id, act, want);
        end
    endtask

    // Monitor: compare every queued expectation against the live DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("taken",   e.id, {7'd0, taken},   {7'd0, e.taken});
                chk("add_in1", e.id, add_in1,         e.in1);
                chk("add_in2", e.id, add_in2,         e.in2);
                chk("pc",      e.id, pc,              e.pc);
                chk("running", e.id, {7'd0, running}, {7'd0, e.running});
                chk("halted",  e.id, {7'd0, halted},  {7'd0, e.halted});
`ifdef PC_SEQ_RAS_EN
                chk("ras_err", e.id, {7'd0, ras_err}, {7'd0, e.err});
`endif
            end
        end
    end

    initial begin
        logic [2:0] bt;
        do_reset();
        // pc_write while IDLE must not move the pc
        step(0, 1, SEQ, 0, 0, 0, 0);
        step(1, 0, SEQ, 0, 0, 0, 0);
        repeat (3) step(0, 1, SEQ, 0, 0, 0, 0);
        step(0, 0, SEQ, 0, 0, 0, 0);
        // conditional branches on registered flags
        go_to(8'h10);
        step(0, 0, SEQ, 0, 0, 1, 1);
        step(0, 1, BZ, 8'h05, 0, 0, 0);
        step(0, 1, BNZ, 8'h07, 0, 0, 0);
        // simultaneous flags_write uses the old Z=1
        step(0, 1, BZ, 8'h04, 0, 0, 1);
        step(0, 1, BZ, 8'h04, 0, 0, 0);
        // wrap-around
        go_to(8'hFF);
        step(0, 1, SEQ, 0, 0, 0, 0);
        go_to(8'h03);
        step(0, 1, BR, 8'hFB, 0, 0, 0);
        step(0, 0, SEQ, 0, 1, 0, 1);
        step(0, 1, BPZ, 8'h20, 0, 0, 0);
        // HALT holds pc against further writes and start
        go_to(8'h20);
        step(0, 1, HALT, 8'h11, 0, 0, 0);
        step(1, 1, SEQ, 0, 0, 0, 0);
        step(1, 1, BR, 8'h33, 0, 0, 0);
        do_reset();
        step(0, 0, SEQ, 0, 0, 0, 0);
`ifdef PC_SEQ_RAS_EN
        step(1, 0, SEQ, 0, 0, 0, 0);
        go_to(8'h30);
        step(0, 1, CALL, 8'h10, 0, 0, 0);
        step(0, 1, RET, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, CALL, 8'h08, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, RET, 8'h00, 0, 0, 0);
        go_to(8'h50);
        step(0, 1, RET, 8'h00, 0, 0, 0);
        step(0, 0, SEQ, 0, 0, 0, 0);
`endif
        // randomized phase with periodic resets
        for (int r = 0; r < 4; r++) begin
            do_reset();
            step(1, 0, SEQ, 0, 0, 0, 0);
            for (int i = 0; i < 120; i++) begin
                bt = 3'($urandom_range(0, 6));
                if ($urandom_range(0, 59) == 0) bt = HALT;
                step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, bt, 8'($urandom),
                     1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
            end
        end
        repeat (2) @(negedge clock);
        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly upstream of the 8-bit PC adder.
- Holds the PC and drives both adder operands: PC with +1, PC with a signed branch offset, or a return address with +1.
- Captures the adder sum as the next PC when the control FSM asserts pc_write.
- Evaluates conditional branches against registered N/Z flags and owns a run/halt state machine.

Parameters:
- WIDTH, 8, data/PC width; must match the adder.
- RESET_PC, 8'h00, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries; used only with RAS_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE.
- pc_write  in  1  commit next PC this cycle.
- br_type  in  3  000 SEQ, 001 BR, 010 BZ, 011 BNZ, 100 BPZ, 101 CALL, 110 RET, 111 HALT.
- br_offset  in  WIDTH  signed two's-complement branch displacement.
- flag_n  in  1  ALU negative flag.
- flag_z  in  1  ALU zero flag.
- flags_write  in  1  latch flag_n/flag_z.
- add_sum  in  WIDTH  sum returned from the PC adder.
- add_in1  out  WIDTH  adder operand 1.
- add_in2  out  WIDTH  adder operand 2.
- pc  out  WIDTH  current PC.
- taken  out  1  branch-taken decision for the current br_type.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- ras_err  out  1  sticky stack overflow/underflow; present only with RAS_EN.

Behaviour:
- Reset (async, reset low):
  - pc=RESET_PC; state=IDLE; flags N=0, Z=0.
  - running=0, halted=0, ras_err=0; RAS pointer=0, count=0.
- FSM:
  - IDLE --start--> RUN (next edge).
  - RUN --pc_write with br_type=HALT--> HALT.
  - HALT exits only via reset.
  - start is ignored in RUN and HALT.
- pc_write is honoured only in RUN; in IDLE and HALT the pc holds and the RAS is untouched.
- Flag register: updated on the edge when flags_write=1. Branches always use the registered flags, so a simultaneous flags_write and pc_write use the old flags.
- taken is combinational:
  - BR, CALL: 1.
  - BZ: Z.
  - BNZ: !Z.
  - BPZ: !N.
  - SEQ, RET, HALT: 0.
  - Forced to 0 outside RUN.
- Operand mux (combinational):
  - taken: add_in1=pc, add_in2=br_offset.
  - RET: add_in1=RAS top, add_in2=1.
  - Otherwise: add_in1=pc, add_in2=1.
- Next PC:
  - On a pc_write edge, pc <= add_sum for SEQ, BR, BZ, BNZ, BPZ, CALL and RET.
  - HALT leaves pc unchanged.
  - The external adder has zero latency; the sum is sampled the same cycle.
- Arithmetic is modulo 2^WIDTH.
  - pc=FF, SEQ: pc -> 00.
  - pc=02, offset=FE: pc -> 00.
- Outputs running and halted are registered state decodes.

Optional Feature:
- Macro: PC_SEQ_RAS_EN.
- With the macro defined:
  - RAS_DEPTH-entry circular return-address stack.
  - CALL pushes the current pc, then jumps to pc+offset.
  - RET pops; the next pc is the popped value +1.
  - Push when full overwrites the oldest entry and sets ras_err.
  - Pop when empty: pc <= pc+1, stack unchanged, ras_err set.
  - ras_err is sticky until reset.
- Without the macro:
  - No stack storage and no ras_err port.
  - CALL behaves exactly as BR.
  - RET behaves exactly as SEQ.

Test Plan:
- Reset then start; three pc_write SEQ cycles with the adder modelled -> pc 00, 01, 02, 03. pc_write during IDLE -> pc stays 00.
- Conditional branches:
  - flags_write with flag_z=1; at pc=10, BZ offset=05 -> taken=1, add_in2=05, pc=15.
  - BNZ at pc=15 -> taken=0, pc=16.
- Same-cycle flags: flags_write (Z=0) together with pc_write BZ while the registered Z=1 -> branch taken on old flag, pc=pc+offset.
- Wrap-around:
  - pc=FF, SEQ -> 00.
  - pc=03, BR offset=FB -> FE.
  - flag_n=1, BPZ -> not taken.
- HALT at pc=20 -> halted=1, running=0, pc stays 20 despite further pc_write and start. Async reset mid-cycle -> pc=00, state IDLE immediately.
- PC_SEQ_RAS_EN stack:
  - CALL at 30 with offset=10 -> pc=40.
  - RET -> pc=31.
  - Five CALLs with depth 4 -> ras_err=1.
  - RET on empty stack at pc=50 -> pc=51, ras_err stays 1.
